// File: rtl/dcache_icache_refill_arbiter_pkg.sv
// Shared cache-types package for the refill arbiter: requester ID and request
// payload types plus the microarchitectural constants they derive from.
package dcache_icache_refill_arbiter_pkg;

    localparam int unsigned CONF_DCACHE_MSHR_NUM      = 2;
    localparam int unsigned CONF_DCACHE_LINE_BYTE_NUM = 8;

    localparam int unsigned REFILL_REQ_NUM         = 1 + CONF_DCACHE_MSHR_NUM;
    localparam int unsigned REFILL_MAX_OUTSTANDING = 4;
    localparam int unsigned REFILL_ADDR_WIDTH      = 32;
    localparam int unsigned REFILL_LINE_WIDTH      = CONF_DCACHE_LINE_BYTE_NUM * 8;
    localparam int unsigned REFILL_ID_WIDTH =
        (REFILL_REQ_NUM > 1) ? $clog2(REFILL_REQ_NUM) : 1;

    typedef logic [REFILL_ID_WIDTH-1:0] RefillReqId;

    typedef struct packed {
        logic [REFILL_ADDR_WIDTH-1:0] addr;
        logic                         isWrite;
        logic [REFILL_LINE_WIDTH-1:0] wdata;
    } RefillReq;

    // (ptr + offset) mod n, valid for ptr < n and offset <= n.
    function automatic int unsigned rr_index(int unsigned ptr, int unsigned offset,
                                             int unsigned n);
        int unsigned idx;
        idx = ptr + offset;
        if (idx >= n) idx = idx - n;
        return idx;
    endfunction

endpackage

// File: rtl/dcache_icache_refill_arbiter_if.sv
// Requester-side and memory-side signals of the refill arbiter. The master
// modport is the arbiter's view; slave is the surrounding environment.
interface dcache_icache_refill_arbiter_if #(
    parameter int unsigned REQ_NUM    = 3,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 64
);
    logic [REQ_NUM-1:0]                 req_valid;
    logic [REQ_NUM-1:0][ADDR_WIDTH-1:0] req_addr;
    logic [REQ_NUM-1:0]                 req_is_write;
    logic [REQ_NUM-1:0][LINE_WIDTH-1:0] req_wdata;
    logic [REQ_NUM-1:0]                 req_grant;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_is_write;
    logic [LINE_WIDTH-1:0] mem_req_wdata;
    logic                  mem_rsp_valid;
    logic [LINE_WIDTH-1:0] mem_rsp_data;

    logic [REQ_NUM-1:0]    rsp_valid;
    logic [LINE_WIDTH-1:0] rsp_data;

    modport master (
        input  req_valid, req_addr, req_is_write, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_grant, mem_req_valid, mem_req_addr, mem_req_is_write, mem_req_wdata,
        output rsp_valid, rsp_data
    );

    modport slave (
        output req_valid, req_addr, req_is_write, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_grant, mem_req_valid, mem_req_addr, mem_req_is_write, mem_req_wdata,
        input  rsp_valid, rsp_data
    );
endinterface

// File: rtl/dcache_icache_refill_arbiter_refill_id_queue.sv
// In-order circular FIFO of requester IDs for transactions issued to memory
// and still awaiting their response.
module refill_id_queue
    import dcache_icache_refill_arbiter_pkg::*;
#(
    parameter int unsigned Depth   = REFILL_MAX_OUTSTANDING,
    parameter int unsigned IdWidth = $bits(RefillReqId)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [IdWidth-1:0]         push_id,
    input  logic                       pop,
    output logic [IdWidth-1:0]         head,
    output logic [$clog2(Depth+1)-1:0] count,
    output logic                       empty
);
    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntWidth = $clog2(Depth + 1);

    logic [IdWidth-1:0]  mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0] count_q;

    function automatic logic [PtrWidth-1:0] ptr_next(logic [PtrWidth-1:0] ptr);
        return (ptr == PtrWidth'(Depth - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/dcache_icache_refill_arbiter.sv
// Round-robin arbiter sharing one refill/writeback memory port between the
// I-cache and the D-cache MSHRs, with in-order response routing.
module dcache_icache_refill_arbiter
    import dcache_icache_refill_arbiter_pkg::*;
#(
    parameter int unsigned REQ_NUM         = REFILL_REQ_NUM,
    parameter int unsigned MAX_OUTSTANDING = REFILL_MAX_OUTSTANDING,
    parameter int unsigned ADDR_WIDTH      = REFILL_ADDR_WIDTH,
    parameter int unsigned LINE_WIDTH      = REFILL_LINE_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,
    dcache_icache_refill_arbiter_if.master bus,
    output logic                           busy,
    output logic                           err
);
    localparam int unsigned IdWidth  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int unsigned CntWidth = $clog2(MAX_OUTSTANDING + 1);

    logic                  reg_valid_q;
    logic [IdWidth-1:0]    reg_id_q;
    logic [ADDR_WIDTH-1:0] reg_addr_q;
    logic                  reg_is_write_q;
    logic [LINE_WIDTH-1:0] reg_wdata_q;
    logic [IdWidth-1:0]    rr_ptr_q;
    logic                  err_q;

    logic                  any_valid;
    logic [IdWidth-1:0]    winner;
    logic [IdWidth-1:0]    cand;
    logic                  drain;
    logic                  capture;
    logic                  credit_ok;
    logic [CntWidth:0]     in_flight;
    logic                  q_pop;
    logic                  q_empty;
    logic [IdWidth-1:0]    q_head;
    logic [CntWidth-1:0]   q_count;

    // First valid requester after rr_ptr wins.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= REQ_NUM; i++) begin
            cand = IdWidth'(rr_index(32'(rr_ptr_q), i, REQ_NUM));
            if (!any_valid && bus.req_valid[cand]) begin
                any_valid = 1'b1;
                winner    = cand;
            end
        end
    end

    assign drain = reg_valid_q && bus.mem_req_ready;

    // Draining only moves an entry from the register to the queue, and a
    // same-cycle pop is not counted, so credit uses start-of-cycle occupancy.
    assign in_flight = {1'b0, q_count} + {{CntWidth{1'b0}}, reg_valid_q};
    assign credit_ok = in_flight < (CntWidth + 1)'(MAX_OUTSTANDING);
    assign capture   = any_valid && (!reg_valid_q || drain) && credit_ok;
    assign q_pop     = bus.mem_rsp_valid && !q_empty;

    always_comb begin
        bus.req_grant = '0;
        if (capture) bus.req_grant[winner] = 1'b1;
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (q_pop) bus.rsp_valid[q_head] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_valid_q    <= 1'b0;
            reg_id_q       <= '0;
            reg_addr_q     <= '0;
            reg_is_write_q <= 1'b0;
            reg_wdata_q    <= '0;
            rr_ptr_q       <= IdWidth'(REQ_NUM - 1);
            err_q          <= 1'b0;
        end else begin
            if (capture) begin
                reg_valid_q    <= 1'b1;
                reg_id_q       <= winner;
                reg_addr_q     <= bus.req_addr[winner];
                reg_is_write_q <= bus.req_is_write[winner];
                reg_wdata_q    <= bus.req_wdata[winner];
                rr_ptr_q       <= winner;
            end else if (drain) begin
                reg_valid_q <= 1'b0;
            end
            if (bus.mem_rsp_valid && q_empty) err_q <= 1'b1;
        end
    end

    refill_id_queue #(
        .Depth   (MAX_OUTSTANDING),
        .IdWidth (IdWidth)
    ) u_id_queue (
        .clk     (clk),
        .rst     (rst),
        .push    (drain),
        .push_id (reg_id_q),
        .pop     (q_pop),
        .head    (q_head),
        .count   (q_count),
        .empty   (q_empty)
    );

    assign bus.mem_req_valid    = reg_valid_q;
    assign bus.mem_req_addr     = reg_addr_q;
    assign bus.mem_req_is_write = reg_is_write_q;
    assign bus.mem_req_wdata    = reg_wdata_q;
    assign bus.rsp_data         = bus.mem_rsp_data;
    assign busy                 = reg_valid_q || !q_empty;
    assign err                  = err_q;

endmodule

// File: tb/tb_dcache_icache_refill_arbiter.sv
// Self-checking bench for the refill arbiter: vector table for round-robin
// order plus hand-written sequences, with an issue/response scoreboard.
module tb_dcache_icache_refill_arbiter;
    import dcache_icache_refill_arbiter_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned LW = 64;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;

    always #5 clk = ~clk;

    dcache_icache_refill_arbiter_if #(.REQ_NUM(N), .ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    dcache_icache_refill_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .err  (err)
    );

    typedef struct {
        logic [1:0] id;
        RefillReq   req;
    } exp_t;

    typedef struct {
        logic [N-1:0] v;
        logic         rdy;
        logic [N-1:0] g;
    } vec_t;

    exp_t        issue_q[$];
    logic [1:0]  rsp_q[$];
    logic [AW-1:0] cur_addr [N];
    logic [LW-1:0] next_data;
    logic        err_exp;
    int          checks = 0;
    int          passes = 0;
    vec_t        tbl [14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [LW-1:0] wdata_of(input logic [AW-1:0] a);
        return {a, ~a};
    endfunction

    // One clock cycle: drive at negedge, check 1 time unit later.
    task automatic cycle(input logic [N-1:0] v, input logic rdy, input logic rsp,
                         input logic [N-1:0] g);
        exp_t         e;
        logic [N-1:0] exp_rsp;
        logic [1:0]   gid;
        logic [1:0]   owner;
        logic [LW-1:0] d;
        @(negedge clk);
        d = next_data;
        bus.req_valid = v;
        for (int i = 0; i < N; i++) begin
            bus.req_addr[i]     = cur_addr[i];
            bus.req_is_write[i] = (i == 1);
            bus.req_wdata[i]    = wdata_of(cur_addr[i]);
        end
        bus.mem_req_ready = rdy;
        bus.mem_rsp_valid = rsp;
        bus.mem_rsp_data  = d;
        next_data = {$urandom(), $urandom()};
        #1;
        check("busy", busy, (issue_q.size() + rsp_q.size()) != 0);
        check("err", err, err_exp);
        check("mem_req_valid", bus.mem_req_valid, issue_q.size() != 0);
        if (issue_q.size() != 0) begin
            e = issue_q[0];
            check("mem_req_addr", bus.mem_req_addr, e.req.addr);
            check("mem_req_is_write", bus.mem_req_is_write, e.req.isWrite);
            check("mem_req_wdata", bus.mem_req_wdata, e.req.wdata);
        end
        exp_rsp = '0;
        if (rsp) begin
            if (rsp_q.size() != 0) begin
                owner = rsp_q.pop_front();
                exp_rsp[owner] = 1'b1;
                check("rsp_data", bus.rsp_data, d);
            end else begin
                err_exp = 1'b1;
            end
        end
        check("rsp_valid", bus.rsp_valid, exp_rsp);
        if (issue_q.size() != 0 && rdy) begin
            e = issue_q.pop_front();
            rsp_q.push_back(e.id);
        end
        check("req_grant", bus.req_grant, g);
        if (g != '0) begin
            gid = 2'd0;
            for (int i = 0; i < N; i++) if (g[i]) gid = 2'(i);
            e.id          = gid;
            e.req.addr    = cur_addr[gid];
            e.req.isWrite = (gid == 2'd1);
            e.req.wdata   = wdata_of(cur_addr[gid]);
            issue_q.push_back(e);
            cur_addr[gid] = cur_addr[gid] + 32'h40;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid     = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue_q.delete();
        rsp_q.delete();
        err_exp = 1'b0;
    endtask

    task automatic drain_all();
        for (int k = 0; k < 20 && (issue_q.size() + rsp_q.size()) != 0; k++)
            cycle('0, 1'b1, rsp_q.size() != 0, '0);
        cycle('0, 1'b1, 1'b0, '0);
    endtask

    initial begin
        int granted;
        logic [N-1:0] v;
        logic [N-1:0] g;

        rst = 1'b1;
        err_exp = 1'b0;
        next_data = 64'h0;
        cur_addr[0] = 32'h1000;
        cur_addr[1] = 32'h2000;
        cur_addr[2] = 32'h3000;
        bus.req_valid = '0;
        bus.req_addr = '0;
        bus.req_is_write = '0;
        bus.req_wdata = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data = '0;

        tbl[0]  = '{3'b111, 1'b1, 3'b001};
        tbl[1]  = '{3'b111, 1'b1, 3'b010};
        tbl[2]  = '{3'b111, 1'b1, 3'b100};
        tbl[3]  = '{3'b111, 1'b0, 3'b000};
        tbl[4]  = '{3'b111, 1'b1, 3'b001};
        tbl[5]  = '{3'b110, 1'b1, 3'b010};
        tbl[6]  = '{3'b110, 1'b1, 3'b100};
        tbl[7]  = '{3'b110, 1'b1, 3'b010};
        tbl[8]  = '{3'b101, 1'b1, 3'b100};
        tbl[9]  = '{3'b101, 1'b1, 3'b001};
        tbl[10] = '{3'b011, 1'b1, 3'b010};
        tbl[11] = '{3'b011, 1'b1, 3'b001};
        tbl[12] = '{3'b100, 1'b1, 3'b100};
        tbl[13] = '{3'b000, 1'b1, 3'b000};

        // Single read from the I-cache.
        do_reset();
        cycle(3'b001, 1'b1, 1'b0, 3'b001);
        cycle(3'b000, 1'b1, 1'b0, 3'b000);
        next_data = 64'hDEAD;
        cycle(3'b000, 1'b1, 1'b1, 3'b000);
        cycle(3'b000, 1'b1, 1'b0, 3'b000);

        // Round-robin order from the table.
        do_reset();
        for (int i = 0; i < 14; i++)
            cycle(tbl[i].v, tbl[i].rdy, rsp_q.size() != 0, tbl[i].g);
        drain_all();

        // Memory stall: payload stable, no further grant.
        do_reset();
        cycle(3'b010, 1'b0, 1'b0, 3'b010);
        for (int i = 0; i < 5; i++) cycle(3'b010, 1'b0, 1'b0, 3'b000);
        cycle(3'b010, 1'b1, 1'b0, 3'b010);
        cycle(3'b000, 1'b1, 1'b0, 3'b000);
        drain_all();

        // Outstanding limit, then push+pop at count 3.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(3'b001, 1'b1, 1'b0, 3'b001);
        cycle(3'b001, 1'b1, 1'b0, 3'b000);
        cycle(3'b001, 1'b1, 1'b0, 3'b000);
        cycle(3'b001, 1'b1, 1'b1, 3'b000);
        cycle(3'b001, 1'b1, 1'b0, 3'b001);
        cycle(3'b000, 1'b1, 1'b1, 3'b000);
        cycle(3'b001, 1'b1, 1'b0, 3'b001);
        drain_all();

        // Twenty transactions around count 3 to wrap the queue pointers.
        do_reset();
        granted = 0;
        for (int k = 0; k < 80 && granted < 20; k++) begin
            v = 3'b100;
            g = ((issue_q.size() + rsp_q.size()) < 4) ? 3'b100 : 3'b000;
            cycle(v, 1'b1, rsp_q.size() >= 3, g);
            if (g != '0) granted++;
        end
        drain_all();

        // Response with nothing outstanding: sticky err until reset.
        do_reset();
        cycle(3'b000, 1'b1, 1'b1, 3'b000);
        for (int i = 0; i < 3; i++) cycle(3'b000, 1'b1, 1'b0, 3'b000);
        cycle(3'b001, 1'b0, 1'b0, 3'b001);
        do_reset();
        cycle(3'b000, 1'b0, 1'b0, 3'b000);

        // Reset with two in flight and the register full.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(3'b001, 1'b1, 1'b0, 3'b001);
        do_reset();
        cycle(3'b111, 1'b1, 1'b0, 3'b001);
        cycle(3'b000, 1'b1, 1'b0, 3'b000);
        drain_all();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/dcache_icache_refill_arbiter.md
# dcache_icache_refill_arbiter

Shares the single refill/writeback memory port between the I-cache miss handler and the D-cache MSHRs. Arbitrates round-robin, buffers the winning request in one output register, and tracks in-flight transactions in an in-order ID queue. Memory responses are routed back to the originating requester. Sits between the cache miss logic and the memory interface.

## Interface
- REQ_NUM, default 1 + CONF_DCACHE_MSHR_NUM (= 3): requester count; index 0 = I-cache, 1..REQ_NUM-1 = D-cache MSHRs.
- MAX_OUTSTANDING, default 4: in-flight limit, counting register plus queue; power of two.
- ADDR_WIDTH, default 32: address width.
- LINE_WIDTH, default CONF_DCACHE_LINE_BYTE_NUM*8 (= 64): line data width.
- clk  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  [REQ_NUM]  request pending; held until granted.
- req_addr  in  [REQ_NUM][ADDR_WIDTH]  line address.
- req_is_write  in  [REQ_NUM]  1 = writeback, 0 = refill read.
- req_wdata  in  [REQ_NUM][LINE_WIDTH]  writeback data.
- req_grant  out  [REQ_NUM]  one-hot pulse; request captured this cycle.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr / mem_req_is_write / mem_req_wdata  out  ADDR_WIDTH / 1 / LINE_WIDTH  request payload.
- mem_rsp_valid  in  1  in-order response, one per request (write ack included).
- mem_rsp_data  in  LINE_WIDTH  read data; don't-care for writes.
- rsp_valid  out  [REQ_NUM]  one-hot response strobe to the owner.
- rsp_data  out  LINE_WIDTH  equals mem_rsp_data.
- busy  out  1  register valid or queue non-empty.
- err  out  1  sticky protocol error.

## Operation
- Output register (valid, id, payload) holds the winning request. drain = mem_req_valid && mem_req_ready.
- Capture condition: at least one req_valid; register empty or draining this cycle; queue_count + reg_valid < MAX_OUTSTANDING. A pop in the same cycle adds no credit.
- Round-robin: search starts at rr_ptr+1 mod REQ_NUM; the first valid requester wins. rr_ptr updates to the winner only on capture.
- On drain, push the register id into the ID queue. On mem_rsp_valid with a non-empty queue, pop the head; rsp_valid[head] = 1.
- Push and pop in the same cycle: count unchanged, both pointers advance, wrap mod MAX_OUTSTANDING.
- mem_rsp_valid with an empty queue: no pop, rsp_valid all 0, err set to 1 until rst.
- Payload is stable while mem_req_valid && !mem_req_ready. A request is never withdrawn.
- Reset values: mem_req_valid 0, req_grant 0, rsp_valid 0, busy 0, err 0, queue empty, rr_ptr = REQ_NUM-1, so requester 0 wins first.
- Reset mid-operation clears the register and queue. The environment must not deliver responses for pre-reset requests; any such response raises err.

## Timing
- req_grant is combinational in capture cycle N. mem_req_valid goes to 1 in N+1 with the captured payload. The requester may drop req_valid in N+1.
- Back-to-back: with mem_req_ready held at 1, one capture and one drain per cycle, i.e. full throughput.
- Responses: rsp_valid and rsp_data are combinational from mem_rsp_valid and the queue head, zero-cycle latency. The minimum request-to-response time is set by memory.
- busy is registered state: it reflects register and queue contents at the start of the cycle.

## Structure
- Shared cache-types package holds:
  - RefillReqId typedef, $clog2(REQ_NUM) bits.
  - RefillReq struct (addr, isWrite, wdata).
  - REFILL_REQ_NUM and REFILL_MAX_OUTSTANDING constants derived from MicroArchConf.
- Sub-module refill_id_queue: circular FIFO of RefillReqId, depth MAX_OUTSTANDING, with push, pop, count, head and empty.
- Arbiter, output register and error logic stay in the top module.

## Test plan
- Reset, then requester 0 valid alone (addr 0x1000, read), ready = 1 → req_grant = 001 at cycle 1; mem_req_valid with addr 0x1000 at cycle 2; response 0xDEAD → rsp_valid = 001, rsp_data 0xDEAD.
- All three valid continuously, ready = 1 → grants 0, 1, 2, 0, …; one per cycle; IDs are returned in issue order.
- mem_req_ready = 0 for 5 cycles with a pending request → payload stable and no further grant; with 4 in flight, a 5th request waits until a response pops.
- Push and pop in the same cycle at count 3 → count stays 3; pointers wrap correctly over 20 transactions.
- mem_rsp_valid with an empty queue → rsp_valid = 000, err = 1 and stays 1 until rst; rst then clears err, busy and mem_req_valid next cycle.
- rst asserted with 2 in flight and the register full → next cycle mem_req_valid 0, busy 0, and requester 0 wins the next arbitration.
